// File: rtl/exp_preprocess_pipe.sv
// -----------------------------------------------------------------------------
// exp_preprocess_pipe
//
// Multi-lane exponent pre-processor for the softmax exp path. Per lane it forms
// (Xi - lnF) * log2(e) in signed fixed point and splits the product into an
// integer exponent u (floor) and a fraction v in [0, 1) for the 2^v / shift
// stages downstream.
//
// Pipeline: three register stages sharing one valid/ready handshake.
//   S1 : a = sext(xi) << FRAC_W - (in_stage4 ? zext(lnF) : 0)
//   S2 : p = a * log2(e), built from arithmetic shifts (truncation to -inf)
//   S3 : floor split, saturation to DATA_W and the underflow (zero) flag
// A stall (out_valid && !out_ready) freezes every stage. Bubbles are kept.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   lnf_load, lnf_in      load the held lnF register (unsigned, FRAC_W frac)
//   in_valid, in_ready    input handshake; in_ready depends on out_ready
//   in_stage4             1: subtract lnF, 0: subtract nothing
//   xi                    LANES signed integers, lane i at [i*DATA_W +: DATA_W]
//   out_valid, out_ready  output handshake
//   u, v                  per-lane saturated floor exponent and fraction
//   zero, sat             per-lane underflow and saturation flags
// -----------------------------------------------------------------------------
module exp_preprocess_pipe #(
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 10,
  parameter int LANES      = 4,
  parameter int LOG2E_MODE = 0,
  parameter int MIN_EXP    = -32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lnf_load,
  input  logic [DATA_W-1:0]       lnf_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_stage4,
  input  logic [LANES*DATA_W-1:0] xi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] u,
  output logic [LANES*FRAC_W-1:0] v,
  output logic [LANES-1:0]        zero,
  output logic [LANES-1:0]        sat
);

  // Internal datapath width: DATA_W integer bits, FRAC_W fraction bits, plus
  // headroom for the lnF subtraction and the ~1.44x gain of the multiply.
  localparam int W    = DATA_W + FRAC_W + 2;
  localparam int UI_W = W - FRAC_W;

  // Representable range of u, expressed at the width of the raw integer part.
  localparam logic signed [UI_W-1:0] UI_MAX =
    {{(UI_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [UI_W-1:0] UI_MIN =
    {{(UI_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [UI_W-1:0] MIN_EXP_W = UI_W'(MIN_EXP);

  logic                    adv_s;
  logic [DATA_W-1:0]       lnf_r;
  logic                    s1_v_r;
  logic                    s2_v_r;
  logic                    s3_v_r;

  logic signed [W-1:0]     lnf_ext_s;
  logic signed [W-1:0]     xi_ext_s  [LANES];
  logic signed [W-1:0]     a_s       [LANES];
  logic signed [W-1:0]     s1_a_r    [LANES];
  logic signed [W-1:0]     corr_s    [LANES];
  logic signed [W-1:0]     p_s       [LANES];
  logic signed [W-1:0]     s2_p_r    [LANES];
  logic signed [UI_W-1:0]  ui_s      [LANES];
  logic [DATA_W-1:0]       u_s       [LANES];
  logic [FRAC_W-1:0]       v_s       [LANES];
  logic [LANES-1:0]        zero_s;
  logic [LANES-1:0]        sat_s;

  logic [LANES*DATA_W-1:0] u_r;
  logic [LANES*FRAC_W-1:0] v_r;
  logic [LANES-1:0]        zero_r;
  logic [LANES-1:0]        sat_r;

  // The whole pipe moves together; it only stops when a result is waiting.
  assign adv_s     = !s3_v_r || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = s3_v_r;
  assign u         = u_r;
  assign v         = v_r;
  assign zero      = zero_r;
  assign sat       = sat_r;

  // S1 combinational: align xi to the fixed-point grid and remove lnF.
  always_comb begin
    lnf_ext_s = $signed({{(W-DATA_W){1'b0}}, lnf_r});
    xi_ext_s  = '{default: {W{1'b0}}};
    a_s       = '{default: {W{1'b0}}};
    for (int i = 0; i < LANES; i++) begin
      xi_ext_s[i] = W'($signed(xi[i*DATA_W +: DATA_W]));
      if (in_stage4) begin
        a_s[i] = (xi_ext_s[i] <<< FRAC_W) - lnf_ext_s;
      end else begin
        a_s[i] = xi_ext_s[i] <<< FRAC_W;
      end
    end
  end

  // S2 combinational: shift-add multiply by log2(e); each term floors.
  always_comb begin
    corr_s = '{default: {W{1'b0}}};
    p_s    = '{default: {W{1'b0}}};
    for (int i = 0; i < LANES; i++) begin
      if (LOG2E_MODE != 0) begin
        corr_s[i] = (s1_a_r[i] >>> 8) + (s1_a_r[i] >>> 10);
      end else begin
        corr_s[i] = {W{1'b0}};
      end
      p_s[i] = s1_a_r[i] + (s1_a_r[i] >>> 1) - (s1_a_r[i] >>> 4) + corr_s[i];
    end
  end

  // S3 combinational: floor split, saturation and underflow detection.
  always_comb begin
    ui_s   = '{default: {UI_W{1'b0}}};
    u_s    = '{default: {DATA_W{1'b0}}};
    v_s    = '{default: {FRAC_W{1'b0}}};
    zero_s = {LANES{1'b0}};
    sat_s  = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      // Taking the upper bits of a two's complement value is already a floor.
      ui_s[i]   = s2_p_r[i][W-1:FRAC_W];
      // Underflow is judged before clamping so very negative inputs still flag.
      zero_s[i] = (ui_s[i] < MIN_EXP_W);
      if (ui_s[i] > UI_MAX) begin
        u_s[i]   = {1'b0, {(DATA_W-1){1'b1}}};
        v_s[i]   = {FRAC_W{1'b1}};
        sat_s[i] = 1'b1;
      end else if (ui_s[i] < UI_MIN) begin
        u_s[i]   = {1'b1, {(DATA_W-1){1'b0}}};
        v_s[i]   = {FRAC_W{1'b0}};
        sat_s[i] = 1'b1;
      end else begin
        u_s[i]   = ui_s[i][DATA_W-1:0];
        v_s[i]   = s2_p_r[i][FRAC_W-1:0];
        sat_s[i] = 1'b0;
      end
    end
  end

  // Held lnF register; a load only affects beats accepted after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lnf_r <= {DATA_W{1'b0}};
    end else if (lnf_load) begin
      lnf_r <= lnf_in;
    end else begin
      lnf_r <= lnf_r;
    end
  end

  // Pipeline registers: valid bits, stage data and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r <= 1'b0;
      s2_v_r <= 1'b0;
      s3_v_r <= 1'b0;
      s1_a_r <= '{default: {W{1'b0}}};
      s2_p_r <= '{default: {W{1'b0}}};
      u_r    <= {(LANES*DATA_W){1'b0}};
      v_r    <= {(LANES*FRAC_W){1'b0}};
      zero_r <= {LANES{1'b0}};
      sat_r  <= {LANES{1'b0}};
    end else if (adv_s) begin
      s1_v_r <= in_valid;
      s2_v_r <= s1_v_r;
      s3_v_r <= s2_v_r;
      s1_a_r <= a_s;
      s2_p_r <= p_s;
      for (int i = 0; i < LANES; i++) begin
        u_r[i*DATA_W +: DATA_W] <= u_s[i];
        v_r[i*FRAC_W +: FRAC_W] <= v_s[i];
      end
      zero_r <= zero_s;
      sat_r  <= sat_s;
    end else begin
      s1_v_r <= s1_v_r;
      s2_v_r <= s2_v_r;
      s3_v_r <= s3_v_r;
    end
  end

endmodule

// File: tb/tb_exp_preprocess_pipe.sv
// -----------------------------------------------------------------------------
// Bench for exp_preprocess_pipe. Two instances share all inputs: one with the
// short log2(e) constant, one with the long one. Every accepted beat is pushed
// to a scoreboard with the lnF value the bench expects at acceptance; every
// cycle with out_valid compares the head against an arithmetic reference
// (explicit floor division), and directed beats also carry hand-derived values.
// -----------------------------------------------------------------------------
module tb_exp_preprocess_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         lnf_load;
  logic [31:0]  lnf_in;
  logic         in_valid;
  logic         in_ready, in_ready1;
  logic         in_stage4;
  logic [127:0] xi;
  logic         out_valid, out_valid1;
  logic         out_ready;
  logic [127:0] u, u1;
  logic [39:0]  v, v1;
  logic [3:0]   zero, zero1, sat, sat1;

  always #5 clk = ~clk;

  exp_preprocess_pipe #(.DATA_W(32), .FRAC_W(10), .LANES(4), .LOG2E_MODE(0), .MIN_EXP(-32)) dut0 (
    .clk(clk), .rst(rst), .lnf_load(lnf_load), .lnf_in(lnf_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_stage4(in_stage4), .xi(xi),
    .out_valid(out_valid), .out_ready(out_ready),
    .u(u), .v(v), .zero(zero), .sat(sat));

  exp_preprocess_pipe #(.DATA_W(32), .FRAC_W(10), .LANES(4), .LOG2E_MODE(1), .MIN_EXP(-32)) dut1 (
    .clk(clk), .rst(rst), .lnf_load(lnf_load), .lnf_in(lnf_in),
    .in_valid(in_valid), .in_ready(in_ready1), .in_stage4(in_stage4), .xi(xi),
    .out_valid(out_valid1), .out_ready(out_ready),
    .u(u1), .v(v1), .zero(zero1), .sat(sat1));

  typedef struct packed {
    logic [31:0] u;
    logic [9:0]  v;
    logic        z;
    logic        s;
  } res_t;

  typedef struct {
    logic [127:0] x;
    logic [31:0]  lnf;
    bit           s4;
    bit           hand;
    bit           hmode;
    res_t         hexp;
    int           acc;
    bit           lat;
  } sb_t;

  typedef struct {
    int x;
    bit s4;
    bit m;
    int eu;
    int ev;
    bit ez;
    bit es;
  } vec_t;

  sb_t         sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] lnf_m = 32'd0;
  bit          g_hand = 1'b0;
  bit          g_mode = 1'b0;
  bit          g_lat  = 1'b0;
  res_t        g_exp;
  int          rmode  = 0;

  function automatic longint fdiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic res_t model(input logic [31:0] xin, input logic [31:0] lnf,
                                 input bit s4, input bit m);
    longint a, p, ui, vv;
    res_t   r;
    a = longint'($signed(xin)) * 64'sd1024;
    if (s4) a = a - longint'({32'd0, lnf});
    p = a + fdiv(a, 2) - fdiv(a, 16);
    if (m) p = p + fdiv(a, 256) + fdiv(a, 1024);
    ui = fdiv(p, 1024);
    vv = p - ui * 1024;
    r.z = (ui < -64'sd32);
    if (ui > 64'sd2147483647) begin
      r.u = 32'h7FFFFFFF; r.v = 10'h3FF; r.s = 1'b1;
    end else if (ui < -64'sd2147483648) begin
      r.u = 32'h80000000; r.v = 10'h000; r.s = 1'b1;
    end else begin
      r.u = ui[31:0]; r.v = vv[9:0]; r.s = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int lane, input res_t got, input res_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got u=%0d v=%0d z=%0b s=%0b, expected u=%0d v=%0d z=%0b s=%0b",
               name, lane, $signed(got.u), got.v, got.z, got.s,
               $signed(exp.u), exp.v, exp.z, exp.s);
    end
  endtask

  // cycle counter: value seen at a negedge is the number of posedges so far
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = held off
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // monitor / scoreboard, sampled mid-cycle
  initial begin
    sb_t  e;
    sb_t  n;
    res_t g0, g1;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        lnf_m = 32'd0;
      end else begin
        if (out_valid) begin
          checks++;
          if (!out_valid1) begin
            errors++;
            $display("FAIL mode1_valid: got out_valid=0, expected 1");
          end
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got out_valid=1, expected no pending beat");
          end else begin
            e = sbq[0];
            for (int i = 0; i < 4; i++) begin
              g0 = {u[i*32 +: 32], v[i*10 +: 10], zero[i], sat[i]};
              g1 = {u1[i*32 +: 32], v1[i*10 +: 10], zero1[i], sat1[i]};
              chk("mode0", i, g0, model(e.x[i*32 +: 32], e.lnf, e.s4, 1'b0));
              chk("mode1", i, g1, model(e.x[i*32 +: 32], e.lnf, e.s4, 1'b1));
            end
            if (e.hand) begin
              g0 = {u[31:0], v[9:0], zero[0], sat[0]};
              g1 = {u1[31:0], v1[9:0], zero1[0], sat1[0]};
              chk("directed", 0, e.hmode ? g1 : g0, e.hexp);
            end
            if (e.lat && out_ready) begin
              checks++;
              if (cyc - e.acc != 3) begin
                errors++;
                $display("FAIL latency: got %0d, expected 3", cyc - e.acc);
              end
            end
            if (out_ready) void'(sbq.pop_front());
          end
        end
        if (in_valid && in_ready && in_ready1) begin
          n.x = xi; n.lnf = lnf_m; n.s4 = in_stage4; n.hand = g_hand;
          n.hmode = g_mode; n.hexp = g_exp; n.acc = cyc; n.lat = g_lat;
          sbq.push_back(n);
        end
        if (lnf_load) lnf_m = lnf_in;
      end
    end
  end

  task automatic send(input logic [127:0] x, input bit s4, input bit ld, input logic [31:0] ldv);
    bit acc;
    int n;
    xi = x; in_stage4 = s4; in_valid = 1'b1; lnf_load = ld; lnf_in = ldv;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      lnf_load = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no in_ready in 100 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending beats, expected 0", sbq.size());
    end
  endtask

  function automatic logic [127:0] rand_lanes(input int lane0);
    logic [127:0] x;
    x[31:0] = 32'(lane0);
    for (int i = 1; i < 4; i++) x[i*32 +: 32] = 32'($urandom_range(0, 600)) - 32'd300;
    return x;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[9];
    logic [127:0] x;
    res_t         zr;

    tbl[0] = '{x: 3,           s4: 1'b0, m: 1'b0, eu: 4,           ev: 320,  ez: 1'b0, es: 1'b0};
    tbl[1] = '{x: -2,          s4: 1'b0, m: 1'b0, eu: -3,          ev: 128,  ez: 1'b0, es: 1'b0};
    tbl[2] = '{x: 5,           s4: 1'b1, m: 1'b0, eu: 5,           ev: 32,   ez: 1'b0, es: 1'b0};
    tbl[3] = '{x: 5,           s4: 1'b0, m: 1'b0, eu: 7,           ev: 192,  ez: 1'b0, es: 1'b0};
    tbl[4] = '{x: 3,           s4: 1'b0, m: 1'b1, eu: 4,           ev: 335,  ez: 1'b0, es: 1'b0};
    tbl[5] = '{x: -100,        s4: 1'b0, m: 1'b0, eu: -144,        ev: 256,  ez: 1'b1, es: 1'b0};
    tbl[6] = '{x: -20,         s4: 1'b0, m: 1'b0, eu: -29,         ev: 256,  ez: 1'b0, es: 1'b0};
    tbl[7] = '{x: -22,         s4: 1'b0, m: 1'b0, eu: -32,         ev: 384,  ez: 1'b0, es: 1'b0};
    tbl[8] = '{x: 2147483647,  s4: 1'b0, m: 1'b0, eu: 2147483647,  ev: 1023, ez: 1'b0, es: 1'b1};

    rst = 1'b1; lnf_load = 1'b0; lnf_in = 32'd0; in_valid = 1'b0;
    in_stage4 = 1'b0; xi = 128'd0; g_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    checks++;
    if ({out_valid, u, v, zero, sat} !== 177'd0) begin
      errors++;
      $display("FAIL reset_state: got out_valid=%0b u=%h v=%h zero=%b sat=%b, expected all 0",
               out_valid, u, v, zero, sat);
    end
    rst = 1'b0;

    // lnF = 1.5
    lnf_load = 1'b1; lnf_in = 32'd1536;
    @(posedge clk);
    #1;
    lnf_load = 1'b0;

    // directed table, back to back with out_ready high
    g_lat = 1'b1;
    for (int k = 0; k < 9; k++) begin
      g_hand = 1'b1;
      g_mode = tbl[k].m;
      g_exp  = {32'(tbl[k].eu), 10'(tbl[k].ev), tbl[k].ez, tbl[k].es};
      send(rand_lanes(tbl[k].x), tbl[k].s4, 1'b0, 32'd0);
    end
    g_hand = 1'b0; g_lat = 1'b0;
    drain();

    // backpressure with lnF changing mid-stream
    rmode = 1;
    for (int k = 0; k < 8; k++) begin
      x = rand_lanes(int'($urandom_range(0, 2000)) - 1000);
      if (k == 5) x[63:32] = 32'h80000000;
      send(x, 1'($urandom_range(0, 1)), (k == 2) || (k == 5), 32'($urandom_range(0, 200000)));
    end
    drain();
    rmode = 0;

    // reset with three beats in flight
    lnf_load = 1'b1; lnf_in = 32'd3000;
    @(posedge clk);
    #1;
    lnf_load = 1'b0;
    rmode = 2;
    #1;
    for (int k = 0; k < 3; k++) send(rand_lanes(k + 1), 1'b1, 1'b0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rmode = 0;
    zr = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midstream_valid: got %0b, expected 0", out_valid);
    end
    chk("reset_midstream_out", 0, {u[31:0], v[9:0], zero[0], sat[0]}, zr);

    // lnF must be 0 again: stage 4 with xi=5 gives 7.1875
    g_hand = 1'b1; g_mode = 1'b0; g_exp = {32'd7, 10'd192, 1'b0, 1'b0};
    g_lat = 1'b1;
    send(rand_lanes(5), 1'b1, 1'b0, 32'd0);
    // negative saturation, zero flag from the unsaturated value
    g_exp = {32'h80000000, 10'd0, 1'b1, 1'b1};
    send(rand_lanes(int'(32'h80000000)), 1'b0, 1'b0, 32'd0);
    g_hand = 1'b0; g_lat = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
